// File: rtl/string_hw_initiator_if.sv
// Host command/response and accelerator handshake bundle for string_hw_initiator.
// Strings are packed byte arrays; byte 0 is the first character.
interface string_hw_initiator_if #(
    parameter int MAX_BLOCKS = 8
);
    localparam int NB = MAX_BLOCKS * 4;

    logic                cmd_valid;
    logic                cmd_ready;
    logic [3:0]          cmd_index;
    logic [NB-1:0][7:0]  cmd_a;
    logic [NB-1:0][7:0]  cmd_b;

    logic                go;
    logic [3:0]          index;
    logic [NB-1:0][7:0]  A;
    logic [NB-1:0][7:0]  B;
    logic                done;
    logic [NB-1:0][7:0]  Result;

    logic                rsp_valid;
    logic                rsp_ready;
    logic [NB-1:0][7:0]  rsp_data;
    logic                rsp_error;
    logic                busy;

    modport master (
        input  cmd_valid, cmd_index, cmd_a, cmd_b, done, Result, rsp_ready,
        output cmd_ready, go, index, A, B, rsp_valid, rsp_data, rsp_error, busy
    );

    modport slave (
        output cmd_valid, cmd_index, cmd_a, cmd_b, done, Result, rsp_ready,
        input  cmd_ready, go, index, A, B, rsp_valid, rsp_data, rsp_error, busy
    );
endinterface

// File: rtl/string_hw_initiator.sv
// Single-outstanding command initiator for a string accelerator: issue, wait for done, release, respond.
// Optional WAIT_DONE abort counter enabled by macro STRING_HW_TIMEOUT_EN.
module string_hw_initiator #(
    parameter int MAX_BLOCKS     = 8,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    string_hw_initiator_if.master bus
);
    localparam int NB = MAX_BLOCKS * 4;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ISSUE   = 3'd1;
    localparam logic [2:0] S_WAIT    = 3'd2;
    localparam logic [2:0] S_RELEASE = 3'd3;
    localparam logic [2:0] S_RESP    = 3'd4;

    logic [2:0]         r_state;
    logic [3:0]         r_index;
    logic [NB-1:0][7:0] r_a;
    logic [NB-1:0][7:0] r_b;
    logic [NB-1:0][7:0] r_rsp_data;
    logic               r_rsp_error;
    logic               w_accept;
    logic               w_timeout;

    // A stale done from the previous command must drain before a new one is taken.
    assign bus.cmd_ready = (r_state == S_IDLE) && !bus.done;
    assign w_accept      = bus.cmd_valid && bus.cmd_ready;

    assign bus.go        = (r_state == S_ISSUE) || (r_state == S_WAIT);
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.rsp_valid = (r_state == S_RESP);
    assign bus.index     = r_index;
    assign bus.A         = r_a;
    assign bus.B         = r_b;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.rsp_error = r_rsp_error;

`ifdef STRING_HW_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (r_state == S_ISSUE) begin
            r_cnt <= '0;
        end else if ((r_state == S_WAIT) && !bus.done && (r_cnt != 16'hFFFF)) begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

    // Fires on the WAIT_DONE cycle in which the count would reach TIMEOUT_CYCLES.
    assign w_timeout = (r_state == S_WAIT) && !bus.done && (r_cnt >= TO_LAST);
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_index     <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_rsp_data  <= '0;
            r_rsp_error <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_index <= bus.cmd_index;
                        r_a     <= bus.cmd_a;
                        r_b     <= bus.cmd_b;
                        if (bus.cmd_index <= 4'd2) begin
                            r_state <= S_ISSUE;
                        end else begin
                            r_state     <= S_RESP;
                            r_rsp_data  <= '0;
                            r_rsp_error <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    // done has priority over a coincident timeout.
                    if (bus.done) begin
                        r_rsp_data  <= bus.Result;
                        r_rsp_error <= 1'b0;
                        r_state     <= S_RELEASE;
                    end else if (w_timeout) begin
                        r_rsp_data  <= '0;
                        r_rsp_error <= 1'b1;
                        r_state     <= S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    if (!bus.done) begin
                        r_state <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule
